md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Parametrised, iterative multiply/divide unit for HI/LO-producing instructions (MULT, MULTU, DIV, DIVU).
- Replaces the single-cycle combinational signed multiply in the execute stage.
- Sits beside the execute stage. While busy_o is high, the pipeline stalls issue. Results are returned as a {hi, lo} pair with a one-cycle done pulse, which acts as the HI/LO write enable.

Parameters:
- WIDTH, 32, operand width in bits. Each result half is also WIDTH bits. Must be even and >= 4.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  one clock; reset is asynchronous and active-low (0 = reset).
- start_i  input  1  request pulse; sampled only in IDLE.
- op_i  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU. Sampled with start_i.
- opa_i  input  WIDTH  multiplicand / dividend (rs); sampled with start_i.
- opb_i  input  WIDTH  multiplier / divisor (rt); sampled with start_i.
- cancel_i  input  1  flush; abandons any operation in progress.
- busy_o  output  1  high from the accepting edge until the done edge.
- done_o  output  1  one-cycle pulse; hi_o/lo_o are valid and must be written to HI/LO.
- hi_o  output  WIDTH  product[2W-1:W] for multiply; remainder for divide.
- lo_o  output  WIDTH  product[W-1:0] for multiply; quotient for divide.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0. busy_o=0, done_o=0, hi_o=0, lo_o=0. Internal operand, accumulator and sign registers are cleared. Reset takes effect mid-operation with no done pulse.
- States: IDLE, CALC, FIX.
- IDLE:
  - start_i=1 and cancel_i=0 at edge E0: latch the op. For signed ops, latch operand magnitudes, the result sign (opa^opb for quotient/product, opa for remainder) and counter=0.
  - Then go to CALC, or go to FIX directly on divide-by-zero.
  - busy_o=1 from E0.
- CALC:
  - Multiply: one radix-2 shift-add step per cycle.
  - Divide: one restoring-division step per cycle, over a WIDTH+1-bit partial remainder.
  - counter increments each cycle. After the step with counter=WIDTH-1 (edge E_WIDTH), go to FIX.
- FIX:
  - Apply two's-complement sign correction over the full 2*WIDTH bits.
  - Register hi_o/lo_o, pulse done_o=1 and clear busy_o, all at edge E_(WIDTH+1). Return to IDLE.
  - Normal latency: done_o is high in the cycle after E_(WIDTH+1).
  - start_i asserted in the same cycle as done_o is ignored; a new start is accepted from the next cycle.
- Divide by zero (opb_i=0, DIV or DIVU): skip CALC. Result is lo_o = all ones, hi_o = opa_i as presented (unsigned pattern). done_o asserts after E1.
- Signed overflow (DIV, opa=100..0, opb=all ones): lo_o=100..0, hi_o=0, produced through the normal iterative path. Magnitude arithmetic must use WIDTH+1 bits so that negating 100..0 is exact.
- MULT sign: the sign is decided from the latched operand MSBs. A zero product always yields hi=lo=0 (no negative zero).
- Remainder sign follows the dividend. Quotient truncates toward zero.
- start_i while busy_o=1: ignored, with no queueing.
- cancel_i:
  - In CALC or FIX: next edge goes to IDLE. busy_o=0, no done_o, hi_o/lo_o keep their previous values.
  - In IDLE with start_i=1: cancel wins and nothing is accepted.
- hi_o/lo_o hold their last values between operations. done_o is never high for two consecutive cycles.
- opa_i/opb_i/op_i may change freely after the accepting edge.

Test Plan:
- Reset, then MULT opa=0xFFFFFFFE, opb=0x00000003 -> busy_o for 33 cycles. done_o pulse at the 33rd edge after start with hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA. busy_o=0 in the done cycle.
- MULTU opa=0xFFFFFFFF, opb=0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001. MULT of the same operands -> hi_o=0, lo_o=1.
- DIV opa=0xFFFFFFF9 (-7), opb=2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIVU 100/7 -> lo_o=14, hi_o=2.
- DIVU opa=0x64, opb=0 -> done_o after 1 edge with lo_o=0xFFFFFFFF, hi_o=0x64. DIV 0x80000000 / 0xFFFFFFFF -> lo_o=0x80000000, hi_o=0 after the full latency.
- DIV start, cancel_i at cycle 10 -> busy_o drops next edge, no done_o, hi_o/lo_o unchanged. A start_i held high while busy is not accepted. A new MULT 5*6 issued immediately afterwards -> lo_o=30, hi_o=0.
- rst=0 asynchronously during CALC -> all outputs 0 immediately, no done_o after release. Repeat the MULT case with WIDTH=8: 0xFE*0x03 -> hi=0xFF, lo=0xFA, done at the 9th edge.

Source files
------------

// File: rtl/md_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide, sign fix-up.
// One step per cycle; done_o pulses WIDTH+1 edges after the accepting edge (1 edge on divide-by-zero).
module md_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state, state_nx;
  logic               accept;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               dz;
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   bop;

  logic               sgn_op;
  logic               in_dz;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     add;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic               ge;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign busy_o = (state != IDLE);

  // Magnitudes fit as unsigned WIDTH-bit values, so negating 100..0 is exact.
  assign sgn_op = ~op_i[0];
  assign in_dz  = op_i[1] & (opb_i == '0);
  assign a_mag  = (sgn_op & opa_i[WIDTH-1]) ? (~opa_i + 1'b1) : opa_i;
  assign b_mag  = (sgn_op & opb_i[WIDTH-1]) ? (~opb_i + 1'b1) : opb_i;

  // Multiply keeps {acc, q} as the running product; divide shifts the dividend out of q into acc.
  assign add      = acc + (q[0] ? {1'b0, bop} : '0);
  assign shifted  = {acc[WIDTH-1:0], q[WIDTH-1]};
  assign ge       = (shifted >= {1'b0, bop});
  assign diff     = shifted - {1'b0, bop};
  assign prod     = {acc[WIDTH-1:0], q};
  assign prod_fix = neg_q ? (~prod + 1'b1) : prod;
  assign quot_fix = neg_q ? (~q + 1'b1) : q;
  assign rem_fix  = neg_r ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        // A start coinciding with the done pulse is dropped.
        if (start_i && !cancel_i && !done_o) begin
          accept   = 1'b1;
          state_nx = in_dz ? FIX : CALC;
        end
      end
      CALC: begin
        if (cancel_i)          state_nx = IDLE;
        else if (cnt == LAST)  state_nx = FIX;
      end
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      acc    <= '0;
      q      <= '0;
      bop    <= '0;
      done_o <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
    end else begin
      state  <= state_nx;
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            is_div <= op_i[1];
            neg_q  <= sgn_op & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
            neg_r  <= sgn_op & op_i[1] & opa_i[WIDTH-1];
            dz     <= in_dz;
            cnt    <= '0;
            acc    <= '0;
            q      <= in_dz ? opa_i : a_mag;
            bop    <= b_mag;
          end
        end
        CALC: begin
          if (!cancel_i) begin
            cnt <= cnt + 1'b1;
            if (is_div) begin
              acc <= ge ? diff : shifted;
              q   <= {q[WIDTH-2:0], ge};
            end else begin
              acc <= {1'b0, add[WIDTH:1]};
              q   <= {add[0], q[WIDTH-1:1]};
            end
          end
        end
        FIX: begin
          if (!cancel_i) begin
            done_o <= 1'b1;
            if (dz) begin
              hi_o <= q;
              lo_o <= '1;
            end else if (is_div) begin
              hi_o <= rem_fix;
              lo_o <= quot_fix;
            end else begin
              hi_o <= prod_fix[2*WIDTH-1:WIDTH];
              lo_o <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit (WIDTH=32 plus a WIDTH=8 instance).
module tb_md_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  logic        start8;
  logic [1:0]  op8;
  logic [7:0]  opa8;
  logic [7:0]  opb8;
  logic        cancel8;
  logic        busy8;
  logic        done8;
  logic [7:0]  hi8;
  logic [7:0]  lo8;

  int total;
  int bad;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  md_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .opa_i(opa), .opb_i(opb),
    .cancel_i(cancel), .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
  );

  md_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .op_i(op8), .opa_i(opa8), .opb_i(opb8),
    .cancel_i(cancel8), .busy_o(busy8), .done_o(done8), .hi_o(hi8), .lo_o(lo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation, keep start high for 'hold' cycles after acceptance,
  // scramble operands, and wait (bounded) for done. Returns edges after E0.
  task automatic run32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int hold, output int n, output logic [31:0] h,
                       output logic [31:0] l, output logic bsy);
    bit seen;
    start = 1'b1; op = o; opa = a; opb = b;
    @(posedge clk); #1;
    opa = 32'hDEAD_BEEF; opb = 32'h1234_5678; op = ~o;
    if (hold == 0) start = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (n >= hold) start = 1'b0;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    h = hi; l = lo; bsy = busy;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; cancel = 1'b0; op = 2'b00; opa = '0; opb = '0;
    start8 = 1'b0; cancel8 = 1'b0; op8 = 2'b00; opa8 = '0; opb8 = '0;
    #23;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
    total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mult_basic;
    int n; logic [31:0] h, l; logic bsy;
    run32(MULT, 32'hFFFF_FFFE, 32'h0000_0003, 0, n, h, l, bsy);
    total++; if (n !== 33) begin bad++; $display("FAIL mult_latency got=%0d want=33", n); end
    total++; if (bsy !== 1'b0) begin bad++; $display("FAIL mult_busy_at_done got=%b want=0", bsy); end
    total++; if (h !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h want=ffffffff", h); end
    total++; if (l !== 32'hFFFF_FFFA) begin bad++; $display("FAIL mult_lo got=%h want=fffffffa", l); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_single_pulse got=%b want=0", done); end
  endtask

  task automatic test_mult_full;
    int n; logic [31:0] h, l; logic bsy;
    run32(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, n, h, l, bsy);
    total++; if (h !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi got=%h want=fffffffe", h); end
    total++; if (l !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo got=%h want=00000001", l); end
    @(posedge clk); #1;
    run32(MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, n, h, l, bsy);
    total++; if (h !== 32'h0) begin bad++; $display("FAIL mult_neg_hi got=%h want=0", h); end
    total++; if (l !== 32'h1) begin bad++; $display("FAIL mult_neg_lo got=%h want=1", l); end
    @(posedge clk); #1;
    run32(MULT, 32'h8000_0000, 32'h0000_0000, 0, n, h, l, bsy);
    total++; if ({h, l} !== 64'h0) begin bad++; $display("FAIL mult_zero got=%h want=0", {h, l}); end
    @(posedge clk); #1;
  endtask

  task automatic test_div;
    int n; logic [31:0] h, l; logic bsy;
    run32(DIV, 32'hFFFF_FFF9, 32'h0000_0002, 0, n, h, l, bsy);
    total++; if (n !== 33) begin bad++; $display("FAIL div_latency got=%0d want=33", n); end
    total++; if (l !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_quot got=%h want=fffffffd", l); end
    total++; if (h !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_rem got=%h want=ffffffff", h); end
    @(posedge clk); #1;
    run32(DIVU, 32'd100, 32'd7, 0, n, h, l, bsy);
    total++; if (l !== 32'd14) begin bad++; $display("FAIL divu_quot got=%0d want=14", l); end
    total++; if (h !== 32'd2) begin bad++; $display("FAIL divu_rem got=%0d want=2", h); end
    @(posedge clk); #1;
    run32(DIV, 32'd7, 32'hFFFF_FFFE, 0, n, h, l, bsy);
    total++; if (l !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_negb_quot got=%h want=fffffffd", l); end
    total++; if (h !== 32'd1) begin bad++; $display("FAIL div_negb_rem got=%h want=1", h); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_boundary;
    int n; logic [31:0] h, l; logic bsy;
    run32(DIVU, 32'h0000_0064, 32'h0, 0, n, h, l, bsy);
    total++; if (n !== 1) begin bad++; $display("FAIL dz_latency got=%0d want=1", n); end
    total++; if (l !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_lo got=%h want=ffffffff", l); end
    total++; if (h !== 32'h0000_0064) begin bad++; $display("FAIL dz_hi got=%h want=00000064", h); end
    @(posedge clk); #1;
    run32(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, n, h, l, bsy);
    total++; if (n !== 33) begin bad++; $display("FAIL ovf_latency got=%0d want=33", n); end
    total++; if (l !== 32'h8000_0000) begin bad++; $display("FAIL ovf_lo got=%h want=80000000", l); end
    total++; if (h !== 32'h0) begin bad++; $display("FAIL ovf_hi got=%h want=0", h); end
    @(posedge clk); #1;
  endtask

  task automatic test_cancel;
    int n; int dones; logic [31:0] h, l; logic bsy;
    dones = 0;
    start = 1'b1; op = DIV; opa = 32'd1000; opb = 32'd3;
    @(posedge clk); #1;
    opa = 32'd5; opb = 32'd6; op = MULT;
    for (int c = 1; c < 10; c++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    start = 1'b0; cancel = 1'b1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL cancel_busy_before got=%b want=1", busy); end
    @(posedge clk); #1;
    cancel = 1'b0;
    if (done) dones++;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cancel_busy_after got=%b want=0", busy); end
    total++; if (dones !== 0) begin bad++; $display("FAIL cancel_no_done got=%0d want=0", dones); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL cancel_hi_hold got=%h want=0", hi); end
    total++; if (lo !== 32'h8000_0000) begin bad++; $display("FAIL cancel_lo_hold got=%h want=80000000", lo); end
    run32(MULT, 32'd5, 32'd6, 0, n, h, l, bsy);
    total++; if (n !== 33) begin bad++; $display("FAIL post_cancel_latency got=%0d want=33", n); end
    total++; if (l !== 32'd30) begin bad++; $display("FAIL post_cancel_lo got=%0d want=30", l); end
    total++; if (h !== 32'd0) begin bad++; $display("FAIL post_cancel_hi got=%0d want=0", h); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int n; logic [31:0] h, l; logic bsy;
    run32(MULTU, 32'd7, 32'd9, 20, n, h, l, bsy);
    total++; if (n !== 33) begin bad++; $display("FAIL held_start_latency got=%0d want=33", n); end
    total++; if (l !== 32'd63) begin bad++; $display("FAIL held_start_lo got=%0d want=63", l); end
    start = 1'b1; op = MULTU; opa = 32'd2; opb = 32'd2;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL start_in_done_cycle got=%b want=0", busy); end
    run32(MULTU, 32'd11, 32'd13, 0, n, h, l, bsy);
    total++; if (n !== 33) begin bad++; $display("FAIL b2b_latency got=%0d want=33", n); end
    total++; if (l !== 32'd143) begin bad++; $display("FAIL b2b_lo got=%0d want=143", l); end
    total++; if (h !== 32'd0) begin bad++; $display("FAIL b2b_hi got=%0d want=0", h); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset;
    int dones;
    dones = 0;
    start = 1'b1; op = MULT; opa = 32'd9; opb = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b want=0", busy); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL arst_hi got=%h want=0", hi); end
    total++; if (lo !== 32'h0) begin bad++; $display("FAIL arst_lo got=%h want=0", lo); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL arst_done got=%b want=0", done); end
    #1 rst = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL arst_no_done got=%0d want=0", dones); end
    total++; if (lo !== 32'h0) begin bad++; $display("FAIL arst_lo_after got=%h want=0", lo); end
  endtask

  task automatic test_width8;
    int n; bit seen;
    start8 = 1'b1; op8 = MULT; opa8 = 8'hFE; opb8 = 8'h03;
    @(posedge clk); #1;
    start8 = 1'b0; opa8 = 8'h55; opb8 = 8'hAA;
    n = 0; seen = 1'b0;
    while (!seen && n < 50) begin
      @(posedge clk); #1;
      n++;
      if (done8) seen = 1'b1;
    end
    total++; if (n !== 9) begin bad++; $display("FAIL w8_latency got=%0d want=9", n); end
    total++; if (hi8 !== 8'hFF) begin bad++; $display("FAIL w8_hi got=%h want=ff", hi8); end
    total++; if (lo8 !== 8'hFA) begin bad++; $display("FAIL w8_lo got=%h want=fa", lo8); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL w8_busy_at_done got=%b want=0", busy8); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_mult_basic();
    test_mult_full();
    test_div();
    test_div_boundary();
    test_cancel();
    test_back_to_back();
    test_async_reset();
    test_width8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
